// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and the data stage.
// Data wins ties, except that a bounded starvation guard forces a fetch through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_funct3,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak;
  logic          force_if;
  owner_e        owner, owner_nxt;

  // Grants stay live during reset; only the memory enables are masked.
  always_comb begin
    force_if = if_req & d_req & (streak == STREAK_MAX);
    d_gnt    = d_req & ~force_if;
    if_gnt   = if_req & ~d_gnt;
    if_stall = if_req & ~if_gnt;
    d_stall  = d_req & ~d_gnt;
  end

  always_comb begin
    mem_addr   = if_gnt ? if_addr : d_addr;
    mem_funct3 = if_gnt ? FUNCT3_LW : d_funct3;
    mem_wdata  = d_wdata;
    mem_read   = rst_n & (if_gnt | (d_gnt & ~d_we));
    mem_write  = rst_n & d_gnt & d_we;
  end

  // Streak counts only data grants that actually made a fetch wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      streak <= '0;
    else if (if_gnt || !if_req)
      streak <= '0;
    else if (d_gnt && streak != STREAK_MAX)
      streak <= streak + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner <= OWN_NONE;
    else        owner <= owner_nxt;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt)     owner_nxt = OWN_IF;
    else if (d_gnt) owner_nxt = OWN_D;
  end

  always_comb begin
    if_rvalid = (owner == OWN_IF);
    d_ack     = (owner == OWN_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (if_gnt)          if_rdata <= mem_rdata;
      if (d_gnt && !d_we)  d_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word memory attached.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [5:0]  if_addr, d_addr;
  logic [2:0]  d_funct3;
  logic [31:0] d_wdata;
  logic        if_gnt, if_stall, if_rvalid, d_gnt, d_stall, d_ack;
  logic [31:0] if_rdata, d_rdata;
  logic [5:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_DSTREAK(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b1; if_addr = 6'd1; d_req = 1'b0; d_we = 1'b0;
    d_addr = 6'd0; d_funct3 = 3'b000; d_wdata = 32'h0;
    #2;
    checks++; if (if_rvalid !== 1'b0 || d_ack !== 1'b0) begin errs++; $display("FAIL reset_valid rvalid=%b ack=%b want 0 0", if_rvalid, d_ack); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errs++; $display("FAIL reset_data if_rdata=%h d_rdata=%h want 0 0", if_rdata, d_rdata); end
    checks++; if (if_gnt !== 1'b1 || mem_read !== 1'b0) begin errs++; $display("FAIL reset_mask if_gnt=%b mem_read=%b want 1 0", if_gnt, mem_read); end
    tick;
    checks++; if (if_rvalid !== 1'b0) begin errs++; $display("FAIL reset_hold rvalid=%b want 0", if_rvalid); end
    rst_n = 1'b1; if_req = 1'b0;
    #1;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 6'd5; #1;
    checks++; if (if_gnt !== 1'b1 || if_stall !== 1'b0) begin errs++; $display("FAIL fetch_gnt gnt=%b stall=%b want 1 0", if_gnt, if_stall); end
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 6'd5 || mem_funct3 !== 3'b010)
      begin errs++; $display("FAIL fetch_drive rd=%b wr=%b addr=%0d f3=%b want 1 0 5 010", mem_read, mem_write, mem_addr, mem_funct3); end
    tick; if_req = 1'b0; #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00093) begin errs++; $display("FAIL fetch_data rvalid=%b rdata=%h want 1 00a00093", if_rvalid, if_rdata); end
    tick;
    checks++; if (if_rvalid !== 1'b0) begin errs++; $display("FAIL fetch_pulse rvalid=%b want 0", if_rvalid); end
  endtask

  task automatic test_contention;
    if_req = 1'b1; if_addr = 6'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2; d_funct3 = 3'b010; #1;
    checks++; if (d_gnt !== 1'b1 || if_stall !== 1'b1 || if_gnt !== 1'b0) begin errs++; $display("FAIL cont_c0 d_gnt=%b if_stall=%b if_gnt=%b want 1 1 0", d_gnt, if_stall, if_gnt); end
    checks++; if (mem_addr !== 6'd2 || mem_read !== 1'b1) begin errs++; $display("FAIL cont_c0_drive addr=%0d rd=%b want 2 1", mem_addr, mem_read); end
    tick; d_req = 1'b0; #1;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h00001234 || if_gnt !== 1'b1) begin errs++; $display("FAIL cont_c1 ack=%b rdata=%h if_gnt=%b want 1 00001234 1", d_ack, d_rdata, if_gnt); end
    tick; if_req = 1'b0; #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h33330003 || d_ack !== 1'b0) begin errs++; $display("FAIL cont_c2 rvalid=%b rdata=%h ack=%b want 1 33330003 0", if_rvalid, if_rdata, d_ack); end
    tick;
  endtask

  task automatic test_starvation;
    logic [7:0] want_d;
    logic       prev_d;
    want_d = 8'b0111_0111;  // bit i: cycle i grants data; IF gets cycles 3 and 7
    prev_d = 1'b0;
    if_req = 1'b1; if_addr = 6'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2; #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (d_gnt !== want_d[i] || if_gnt !== ~want_d[i]) begin errs++; $display("FAIL starve_gnt cyc=%0d d_gnt=%b if_gnt=%b want %b %b", i, d_gnt, if_gnt, want_d[i], ~want_d[i]); end
      if (i > 0) begin
        checks++; if (d_ack !== prev_d || if_rvalid !== ~prev_d) begin errs++; $display("FAIL starve_resp cyc=%0d ack=%b rvalid=%b want %b %b", i, d_ack, if_rvalid, prev_d, ~prev_d); end
      end
      prev_d = want_d[i];
      tick;
    end
    if_req = 1'b0; d_req = 1'b0; #1;
    tick;
  endtask

  task automatic test_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd7; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010; #1;
    checks++; if (d_gnt !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 6'd7)
      begin errs++; $display("FAIL store_drive gnt=%b wr=%b rd=%b wdata=%h addr=%0d want 1 1 0 deadbeef 7", d_gnt, mem_write, mem_read, mem_wdata, mem_addr); end
    tick; d_req = 1'b0; #1;
    checks++; if (d_ack !== 1'b1 || mem_write !== 1'b0 || d_rdata !== 32'h00001234) begin errs++; $display("FAIL store_ack ack=%b wr=%b rdata=%h want 1 0 00001234", d_ack, mem_write, d_rdata); end
    tick;
    checks++; if (d_ack !== 1'b0) begin errs++; $display("FAIL store_pulse ack=%b want 0", d_ack); end
    d_req = 1'b1; d_we = 1'b0; #1;
    tick; d_req = 1'b0; #1;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL store_readback ack=%b rdata=%h want 1 deadbeef", d_ack, d_rdata); end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [3:0] want_d;
    want_d = 4'b0111;
    // Build streak to 2 with an ack in flight, then turn the data request into a store.
    if_req = 1'b1; if_addr = 6'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2; #1;
    tick; tick;
    d_we = 1'b1; d_addr = 6'd9; d_wdata = 32'h0BAD0BAD; #1;
    checks++; if (d_gnt !== 1'b1 || mem_write !== 1'b1 || d_ack !== 1'b1) begin errs++; $display("FAIL rmid_pre gnt=%b wr=%b ack=%b want 1 1 1", d_gnt, mem_write, d_ack); end
    rst_n = 1'b0; #1;
    checks++; if (mem_write !== 1'b0 || d_ack !== 1'b0 || if_rvalid !== 1'b0 || d_rdata !== 32'h0) begin errs++; $display("FAIL rmid_async wr=%b ack=%b rvalid=%b rdata=%h want 0 0 0 0", mem_write, d_ack, if_rvalid, d_rdata); end
    tick; rst_n = 1'b1;
    d_we = 1'b0; #1;
    // Streak restarted at 0: three data grants before the fetch is forced.
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_gnt !== want_d[i]) begin errs++; $display("FAIL rmid_streak cyc=%0d d_gnt=%b want %b", i, d_gnt, want_d[i]); end
      tick;
      if (i == 0) begin
        checks++; if (d_rdata !== 32'hA5000009) begin errs++; $display("FAIL rmid_unwritten rdata=%h want a5000009", d_rdata); end
      end
    end
    if_req = 1'b0; d_req = 1'b0; #1;
    tick;
  endtask

  task automatic test_idle;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b1; d_addr = 6'd33; d_funct3 = 3'b101; #1;
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errs++; $display("FAIL idle_en rd=%b wr=%b ig=%b dg=%b want 0 0 0 0", mem_read, mem_write, if_gnt, d_gnt); end
    checks++; if (mem_addr !== 6'd33 || mem_funct3 !== 3'b101) begin errs++; $display("FAIL idle_hold addr=%0d f3=%b want 33 101", mem_addr, mem_funct3); end
    tick;
    checks++; if (if_rvalid !== 1'b0 || d_ack !== 1'b0) begin errs++; $display("FAIL idle_resp rvalid=%b ack=%b want 0 0", if_rvalid, d_ack); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 | i;
    mem[5] = 32'h00A00093;
    mem[2] = 32'h00001234;
    mem[3] = 32'h33330003;
    test_reset;
    test_fetch;
    test_contention;
    test_starvation;
    test_store;
    test_reset_mid;
    test_idle;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
